// File: rtl/a0_monitor_pkg.sv
// Shared widths and the FIFO entry layout for the a0 change monitor.
package a0_monitor_pkg;

    localparam int A0_DATA_WIDTH = 32;
    localparam int A0_TS_WIDTH   = 16;

    typedef struct packed {
        logic [A0_DATA_WIDTH-1:0] data;
        logic [A0_TS_WIDTH-1:0]   ts;
    } a0_entry_t;

endpackage

// File: rtl/a0_monitor_sync_fifo.sv
// Generic synchronous FIFO; full/empty come from an occupancy counter so the
// pointers can simply wrap. clr has priority over push and pop.
module sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wrData,
    output logic [WIDTH-1:0] rdData,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wrPtr_r;
    logic [PW-1:0]    rdPtr_r;
    logic [CW-1:0]    count_r;
    logic             doPush_s;
    logic             doPop_s;

    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});
    assign count  = count_r;
    assign rdData = mem_r[rdPtr_r];

    // Qualify requests: a full FIFO only accepts a push alongside a pop.
    always_comb begin
        doPop_s  = pop && !empty;
        doPush_s = push && (!full || doPop_s);
    end

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (clr) begin
            wrPtr_r <= {PW{1'b0}};
            rdPtr_r <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else begin
            if (doPush_s) begin
                mem_r[wrPtr_r] <= wrData;
                wrPtr_r        <= wrPtr_r + PW'(1);
            end
            if (doPop_s) begin
                rdPtr_r <= rdPtr_r + PW'(1);
            end
            case ({doPush_s, doPop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/a0_monitor.sv
// Records every change of the CPU's a0 register into a FIFO drained over a
// valid/ready stream. Define A0_MONITOR_TIMESTAMP_EN to timestamp each entry.
module a0_monitor
    import a0_monitor_pkg::*;
#(
    parameter  int DATA_WIDTH = A0_DATA_WIDTH,
    parameter  int DEPTH      = 8,
    parameter  int TS_WIDTH   = A0_TS_WIDTH,
    localparam int CW         = $clog2(DEPTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] a0_i,
    input  logic                  en_i,
    input  logic                  clr_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [TS_WIDTH-1:0]   ts_o,
    output logic [CW-1:0]         count_o,
    output logic                  overflow_o
);

`ifdef A0_MONITOR_TIMESTAMP_EN
    localparam int ENTRY_W = DATA_WIDTH + TS_WIDTH;
`else
    localparam int ENTRY_W = DATA_WIDTH;
`endif

    logic [DATA_WIDTH-1:0] last_r;
    logic                  overflow_r;
    logic                  pushReq_s;
    logic                  popReq_s;
    logic                  full_s;
    logic                  empty_s;
    logic [ENTRY_W-1:0]    wrEntry_s;
    logic [ENTRY_W-1:0]    rdEntry_s;
    logic [CW-1:0]         fifoCount_s;

    // Change detection and pop request from the consumer handshake.
    always_comb begin
        pushReq_s = en_i && (a0_i != last_r);
        popReq_s  = !empty_s && ready_i;
    end

    // A dropped change still updates last, so it is never retried.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_r     <= {DATA_WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else if (clr_i) begin
            last_r     <= a0_i;
            overflow_r <= 1'b0;
        end else begin
            if (pushReq_s) begin
                last_r <= a0_i;
            end
            if (pushReq_s && full_s && !popReq_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

`ifdef A0_MONITOR_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] tsCnt_r;

    // Free-running timestamp, wraps silently.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tsCnt_r <= {TS_WIDTH{1'b0}};
        end else begin
            tsCnt_r <= tsCnt_r + TS_WIDTH'(1);
        end
    end

    assign wrEntry_s = {a0_i, tsCnt_r};
    assign data_o    = rdEntry_s[ENTRY_W-1 -: DATA_WIDTH];
    assign ts_o      = rdEntry_s[TS_WIDTH-1:0];
`else
    assign wrEntry_s = a0_i;
    assign data_o    = rdEntry_s;
    assign ts_o      = {TS_WIDTH{1'b0}};
`endif

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk_i),
        .rst_n  (rst_ni),
        .clr    (clr_i),
        .push   (pushReq_s),
        .pop    (popReq_s),
        .wrData (wrEntry_s),
        .rdData (rdEntry_s),
        .full   (full_s),
        .empty  (empty_s),
        .count  (fifoCount_s)
    );

    assign valid_o    = !empty_s;
    assign count_o    = fifoCount_s;
    assign overflow_o = overflow_r;

endmodule

// File: tb/tb_a0_monitor.sv
// Randomised and directed bench for a0_monitor against a queue-based model.
module tb_a0_monitor;

    localparam int DW    = 32;
    localparam int TW    = 16;
    localparam int DEPTH = 8;
    localparam int CW    = 4;
`ifdef A0_MONITOR_TIMESTAMP_EN
    localparam bit TS_ON = 1'b1;
`else
    localparam bit TS_ON = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] a0    = '0;
    logic          en    = 1'b0;
    logic          clr   = 1'b0;
    logic          ready = 1'b0;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [TW-1:0] ts_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;

    always #5 clk = ~clk;

    a0_monitor #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .TS_WIDTH(TW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .a0_i(a0), .en_i(en), .clr_i(clr),
        .ready_i(ready), .valid_o(valid_o), .data_o(data_o), .ts_o(ts_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    int nCmp  = 0;
    int nFail = 0;

    // Behavioural model: a queue of captured entries plus a few scalars.
    logic [DW-1:0] mLast = '0;
    bit            mOvf  = 1'b0;
    int unsigned   mTs   = 0;
    logic [DW-1:0] qData[$];
    logic [TW-1:0] qTs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        qData.delete();
        qTs.delete();
        mLast = '0;
        mOvf  = 1'b0;
        mTs   = 0;
    endtask

    task automatic modelStep();
        bit popNow;
        bit pushNow;
        popNow = (qData.size() > 0) && ready;
        if (clr) begin
            qData.delete();
            qTs.delete();
            mOvf  = 1'b0;
            mLast = a0;
        end else begin
            pushNow = en && (a0 != mLast);
            if (pushNow) mLast = a0;
            if (popNow) begin
                void'(qData.pop_front());
                void'(qTs.pop_front());
            end
            if (pushNow) begin
                if (qData.size() < DEPTH) begin
                    qData.push_back(a0);
                    qTs.push_back(TS_ON ? TW'(mTs) : '0);
                end else begin
                    mOvf = 1'b1;
                end
            end
        end
        mTs = (mTs + 1) % (1 << TW);
    endtask

    task automatic cyc(input logic [DW-1:0] a, input logic e, input logic c, input logic r);
        a0 = a; en = e; clr = c; ready = r;
        @(posedge clk);
        modelStep();
        @(negedge clk);
        #1;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rstValid", 64'(valid_o), 64'(0));
            check("rstCount", 64'(count_o), 64'(0));
            check("rstOvf", 64'(overflow_o), 64'(0));
            check("rstData", 64'(data_o), 64'(0));
            check("rstTs", 64'(ts_o), 64'(0));
        end else begin
            check("valid", 64'(valid_o), 64'(qData.size() > 0));
            check("count", 64'(count_o), 64'(qData.size()));
            check("overflow", 64'(overflow_o), 64'(mOvf));
            if (qData.size() > 0) begin
                check("data", 64'(data_o), 64'(qData[0]));
                check("ts", 64'(ts_o), 64'(qTs[0]));
            end
        end
    end

    initial begin
        logic [TW-1:0] prevTs;
        repeat (2) @(negedge clk);
        #1;
        check("hResetValid", 64'(valid_o), 64'(0));
        check("hResetCount", 64'(count_o), 64'(0));
        rst_n = 1'b1;

        // Step 0 -> 5 after ten idle cycles: timestamp 10, popped next cycle.
        repeat (10) cyc(32'd0, 1'b1, 1'b0, 1'b1);
        cyc(32'd5, 1'b1, 1'b0, 1'b1);
        check("hStepValid", 64'(valid_o), 64'(1));
        check("hStepData", 64'(data_o), 64'(5));
        check("hStepTs", 64'(ts_o), TS_ON ? 64'(10) : 64'(0));
        cyc(32'd5, 1'b1, 1'b0, 1'b1);
        check("hStepDrained", 64'(count_o), 64'(0));

        // Constant value yields one entry.
        repeat (20) cyc(32'd7, 1'b1, 1'b0, 1'b0);
        check("hHoldCount", 64'(count_o), 64'(1));
        cyc(32'd7, 1'b1, 1'b1, 1'b0);

        // Nine changes into eight slots.
        for (int i = 0; i < 9; i++) cyc(DW'(100 + i), 1'b1, 1'b0, 1'b0);
        check("hFullCount", 64'(count_o), 64'(8));
        check("hFullOvf", 64'(overflow_o), 64'(1));
        prevTs = '0;
        for (int i = 0; i < 8; i++) begin
            check("hOrderData", 64'(data_o), 64'(100 + i));
            check("hOrderTs", 64'(ts_o >= prevTs), 64'(1));
            prevTs = ts_o;
            cyc(32'd108, 1'b1, 1'b0, 1'b1);
        end
        check("hDrainCount", 64'(count_o), 64'(0));

        // Push with simultaneous pop while full.
        cyc(32'd200, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) cyc(DW'(201 + i), 1'b1, 1'b0, 1'b0);
        cyc(32'd300, 1'b1, 1'b0, 1'b1);
        check("hPushPopCount", 64'(count_o), 64'(8));
        check("hPushPopOvf", 64'(overflow_o), 64'(0));
        check("hPushPopHead", 64'(data_o), 64'(202));

        // Disabled changes are ignored; re-enable captures current value.
        cyc(32'h50, 1'b1, 1'b1, 1'b0);
        cyc(32'd1, 1'b0, 1'b0, 1'b0);
        cyc(32'd2, 1'b0, 1'b0, 1'b0);
        cyc(32'd3, 1'b0, 1'b0, 1'b0);
        check("hDisabled", 64'(count_o), 64'(0));
        cyc(32'd3, 1'b1, 1'b0, 1'b0);
        check("hEnableCount", 64'(count_o), 64'(1));
        check("hEnableData", 64'(data_o), 64'(3));
        cyc(32'd4, 1'b1, 1'b0, 1'b0);
        cyc(32'd5, 1'b1, 1'b0, 1'b0);
        cyc(32'd5, 1'b1, 1'b1, 1'b0);
        check("hClrCount", 64'(count_o), 64'(0));
        check("hClrValid", 64'(valid_o), 64'(0));
        check("hClrOvf", 64'(overflow_o), 64'(0));

        // Asynchronous reset with four entries queued.
        for (int i = 0; i < 4; i++) cyc(DW'(10 + i), 1'b1, 1'b0, 1'b0);
        check("hPreRstCount", 64'(count_o), 64'(4));
        rst_n = 1'b0;
        modelReset();
        #1;
        check("hAsyncValid", 64'(valid_o), 64'(0));
        check("hAsyncCount", 64'(count_o), 64'(0));
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        cyc(32'h77, 1'b1, 1'b0, 1'b0);
        check("hPostRstData", 64'(data_o), 64'(32'h77));
        check("hPostRstTs", 64'(ts_o), 64'(0));

        // Random traffic over a small value alphabet to force repeats.
        for (int i = 0; i < 3000; i++) begin
            cyc(DW'($urandom_range(0, 3)),
                ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule

// File: doc/a0_monitor.md
Name: a0_monitor

Overview:
- Downstream consumer of the CPU's a0 output; sits between the pipelined core and the display/LED driver or testbench scoreboard.
- Detects every change of a0 and timestamps it with a free-running cycle counter.
- Buffers each change in a small FIFO and presents it over a valid/ready stream.
- Lets slow consumers (e.g. a display refresh) see every a0 update without stalling the core.

Parameters:
- DATA_WIDTH, 32, width of a0 and of captured data.
- DEPTH, 8, FIFO entries; power of two, at least 2.
- TS_WIDTH, 16, timestamp counter width.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  asynchronous active-low reset.
- a0_i  in  DATA_WIDTH  a0 from the CPU register file.
- en_i  in  1  capture enable; when 0, changes are not recorded.
- clr_i  in  1  synchronous flush: empties the FIFO and clears overflow_o.
- ready_i  in  1  consumer ready.
- valid_o  out  1  head entry valid.
- data_o  out  DATA_WIDTH  head entry a0 value.
- ts_o  out  TS_WIDTH  head entry timestamp.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky flag: a change was dropped.

Behaviour:
- Reset (async assert, sync release): FIFO empty, valid_o=0, data_o=0, ts_o=0, count_o=0, overflow_o=0, last-value register=0, timestamp counter=0.
- Timestamp counter:
  - Increments every cycle after reset.
  - Wraps modulo 2^TS_WIDTH with no flag.
  - Unaffected by en_i and clr_i.
- Change detection:
  - push_req = en_i && (a0_i != last).
  - On push_req, last <= a0_i, whether or not the push is accepted. A dropped change is therefore not retried.
  - When en_i=0, last is not updated. Re-enabling while a0_i differs from last captures on the first enabled cycle.
- Entry contents: {a0_i, counter value in the push cycle}.
- Latency: an entry pushed in cycle N appears on valid_o/data_o in cycle N+1 when the FIFO was empty. There is no combinational path from a0_i to the outputs.
- Handshake:
  - Pop occurs when valid_o && ready_i at a clock edge.
  - data_o and ts_o hold stable while valid_o=1 and ready_i=0.
  - valid_o never drops without a pop, clr_i or reset.
- Full:
  - A push with no pop is dropped and sets overflow_o=1.
  - A push with a simultaneous pop is accepted; count stays at DEPTH.
- Empty: a pop is impossible because valid_o=0. A push with ready_i=1 still takes one cycle to appear.
- Simultaneous push and pop when not full: both occur; count unchanged.
- Pointers wrap modulo DEPTH; full/empty are resolved using count, not pointer equality.
- clr_i:
  - Priority over push and pop in the same cycle.
  - Next cycle: count=0, valid_o=0, overflow_o=0.
  - last <= a0_i, so no spurious capture follows.
- Reset mid-operation discards all entries immediately; outputs take their reset values asynchronously.

Optional Feature:
- Macro: A0_MONITOR_TIMESTAMP_EN.
- Defined: timestamp counter present; ts_o carries the captured timestamp.
- Undefined: counter and timestamp storage removed; ts_o tied to 0; all other behaviour identical.

Decomposition:
- Package a0_monitor_pkg holds:
  - typedef a0_entry_t, a packed struct {data, ts} sized from the package constants;
  - constants A0_DATA_WIDTH=32 and A0_TS_WIDTH=16, used as parameter defaults.
- Sub-module sync_fifo (parameters WIDTH and DEPTH; push/pop/clr/full/empty/count), reusable for future buffering in the core.
- a0_monitor holds change detection, the timestamp counter, overflow logic and the handshake glue.

Test Plan:
- Reset, then a0_i steps 0→5 at cycle 10 with ready_i=1 → valid_o=1 at cycle 11, data_o=5, ts_o=10; popped the same cycle; count_o returns to 0.
- a0_i held at 7 for 20 cycles → exactly one entry is captured.
- ready_i=0, with 9 distinct a0 changes on consecutive cycles → count_o=8, the 9th change is dropped, overflow_o=1, entries pop in order with increasing ts_o.
- FIFO full, ready_i=1 and a new change in the same cycle → push accepted, count_o stays 8, overflow_o stays 0.
- en_i=0 while a0 changes 1→2→3, then en_i=1 → a single entry data_o=3. Then clr_i with 3 entries queued → count_o=0, valid_o=0 and overflow_o=0 next cycle.
- rst_ni asserted mid-stream with 4 entries queued → valid_o=0 and count_o=0 asynchronously. After release, with TIMESTAMP_EN undefined, the next capture has ts_o=0.
